wb_bypass_net: RTL and testbench
================================

# wb_bypass_net

Parametrised writeback/bypass network for the backend execution cluster. It collects register writebacks from an arbitrary number of functional-unit ports and re-broadcasts them as a multi-stage bypass vector: one live stage plus BP_DEPTH registered stages. It also arbitrates exception writebacks from EXC_NUM sources into a single registered holder that always contains the oldest pending exception, using wrap-aware ROB age comparison, and delivers it to the ROB with a valid/ready handshake. It sits between the int/mem execution blocks and the ROB/issue-queue wakeup logic.

## Interface
- SRC_NUM, 10: number of writeback sources.
- BP_DEPTH, 2: number of registered bypass stages after the live stage (0 allowed).
- EXC_NUM, 2: number of exception writeback sources.
- IPR_W, 7: physical register index width.
- XLEN, 64: data width.
- ROB_W, 7: ROB index width; MSB is the wrap flag.
- INFO_W, 64: exception payload width, opaque.
- HAS_ZERO, 1: physical register 0 is hardwired zero.
- RD_NUM, 4: lookup ports (only with the macro below).

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_squash_vld  in  1  squash strobe
- i_squash_robIdx  in  ROB_W  oldest squashed ROB entry
- i_wb_vld  in  SRC_NUM  writeback valid per source (already qualified by rd_wen)
- i_wb_iprd  in  SRC_NUM*IPR_W  destination physical register
- i_wb_data  in  SRC_NUM*XLEN  result
- o_bp_vec  out  SRC_NUM*(BP_DEPTH+1)  bypass valid; stage s, source n at bit s*SRC_NUM+n
- o_bp_iprd  out  SRC_NUM*(BP_DEPTH+1)*IPR_W  bypass register index
- o_bp_data  out  SRC_NUM*(BP_DEPTH+1)*XLEN  bypass data
- i_exc_vld  in  EXC_NUM  exception writeback valid
- i_exc_robIdx  in  EXC_NUM*ROB_W  faulting ROB index
- i_exc_info  in  EXC_NUM*INFO_W  payload
- o_exc_vld  out  1  holder valid
- i_exc_ready  in  1  ROB accepts holder
- o_exc_robIdx  out  ROB_W  held ROB index
- o_exc_info  out  INFO_W  held payload
- i_lk_iprd  in  RD_NUM*IPR_W  lookup index (WBNET_LOOKUP_EN only)
- o_lk_hit  out  RD_NUM  lookup hit (WBNET_LOOKUP_EN only)
- o_lk_data  out  RD_NUM*XLEN  lookup data (WBNET_LOOKUP_EN only)

## Operation
- Age: a older than b iff (a.msb==b.msb) ? a.low<b.low : a.low>b.low. Equal indices: not older.
- Stage 0 is combinational from i_wb_*. For HAS_ZERO=1, entries with iprd==0 are masked invalid at stage 0.
- Stage s (1..BP_DEPTH) is stage s-1 registered. Squash does not affect bypass stages, because the writes are architecturally complete in the regfile.
- Exception candidate: the oldest valid i_exc source. Ties on equal robIdx go to the lower source index. With i_squash_vld, sources not older than i_squash_robIdx are dropped before selection.
- Holder update per edge, in priority order:
  - rst: clear.
  - Leaving (o_exc_vld&&i_exc_ready) or squash kills holder (i_squash_vld and holder not older than i_squash_robIdx): holder takes the candidate if one exists, else clears.
  - Otherwise, the candidate replaces the holder only if the holder is empty or the candidate is strictly older.
- A younger candidate arriving while the holder is valid is discarded; the source must not rely on retry.
- The holder changes only at a clock edge.

## Timing
- Reset values: o_bp_vec registered stages 0, o_exc_vld 0, o_exc_robIdx 0, o_exc_info 0. Stage-0 outputs follow inputs.
- Bypass latency: a write at cycle t appears at stage s in cycle t+s and is visible in exactly BP_DEPTH+1 consecutive cycles.
- Exception latency: i_exc_vld at t gives o_exc_vld at t+1 (holder empty).
- Handshake: o_exc_* stays stable while o_exc_vld && !i_exc_ready, except when an older candidate replaces it or a squash kills it.
- BP_DEPTH=0: only stage 0 exists; no bypass registers.
- Wrap-around: msb-differing indices compare by inverted order (e.g. 0x7E older than 0x01 with msb differing).

## Configuration
- WBNET_LOOKUP_EN defined: the RD_NUM lookup ports exist. The lookup is combinational over all stages. Priority goes to the lowest stage (newest), then the lowest source index. With HAS_ZERO, index 0 returns hit=1, data=0.
- Not defined: the lookup ports and logic are absent; the remaining behaviour is identical.

## Test plan
- Bypass pipeline: src 3 writes iprd 5, data 0xAB at t -> stage0 bit 3 at t, stage1 at t+1, stage2 at t+2, nothing at t+3.
- Zero mask: src 0 writes iprd 0 -> no bypass bit at any stage.
- Oldest select: exc src0 rob 0x10, src1 rob 0x0C same cycle -> o_exc_robIdx=0x0C at t+1. Then src0 rob 0x05 with ready=0 -> holder becomes 0x05. Then rob 0x20 -> ignored.
- Wrap: holder msb=1, low 0x02; candidate msb=0, low 0x3E -> candidate older, replaces.
- Squash: holder 0x12, squash 0x10 -> o_exc_vld=0 next cycle. A same-cycle candidate 0x0F survives and loads.
- Lookup (macro on): iprd 9 written at t and t+1 with different data -> lookup at t+1 returns the t+1 data.

Source files
------------

// File: rtl/wb_bypass_net.sv
// Writeback/bypass network: live stage plus BP_DEPTH registered bypass stages, and an
// oldest-first exception holder. Define WBNET_LOOKUP_EN to add the bypass lookup ports.
module wb_bypass_net #(
    parameter int SRC_NUM  = 10,
    parameter int BP_DEPTH = 2,
    parameter int EXC_NUM  = 2,
    parameter int IPR_W    = 7,
    parameter int XLEN     = 64,
    parameter int ROB_W    = 7,
    parameter int INFO_W   = 64,
    parameter int HAS_ZERO = 1,
    parameter int RD_NUM   = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_squash_vld,
    input  logic [ROB_W-1:0]                       i_squash_robIdx,
    input  logic [SRC_NUM-1:0]                     i_wb_vld,
    input  logic [SRC_NUM*IPR_W-1:0]               i_wb_iprd,
    input  logic [SRC_NUM*XLEN-1:0]                i_wb_data,
    output logic [SRC_NUM*(BP_DEPTH+1)-1:0]        o_bp_vec,
    output logic [SRC_NUM*(BP_DEPTH+1)*IPR_W-1:0]  o_bp_iprd,
    output logic [SRC_NUM*(BP_DEPTH+1)*XLEN-1:0]   o_bp_data,
`ifdef WBNET_LOOKUP_EN
    input  logic [RD_NUM*IPR_W-1:0]                i_lk_iprd,
    output logic [RD_NUM-1:0]                      o_lk_hit,
    output logic [RD_NUM*XLEN-1:0]                 o_lk_data,
`endif
    input  logic [EXC_NUM-1:0]                     i_exc_vld,
    input  logic [EXC_NUM*ROB_W-1:0]               i_exc_robIdx,
    input  logic [EXC_NUM*INFO_W-1:0]              i_exc_info,
    output logic                                   o_exc_vld,
    input  logic                                   i_exc_ready,
    output logic [ROB_W-1:0]                       o_exc_robIdx,
    output logic [INFO_W-1:0]                      o_exc_info
);

    localparam int STG = BP_DEPTH + 1;

    // Wrap-aware age: with differing wrap flags the lower-bit order inverts.
    function automatic logic is_older(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] b);
        if (a[ROB_W-1] == b[ROB_W-1])
            return a[ROB_W-2:0] < b[ROB_W-2:0];
        else
            return a[ROB_W-2:0] > b[ROB_W-2:0];
    endfunction

    // ---------------- bypass stages ----------------
    genvar gi;
    generate
        for (gi = 0; gi < SRC_NUM; gi++) begin : g_s0
            assign o_bp_vec[gi] = i_wb_vld[gi] &&
                !((HAS_ZERO != 0) && (i_wb_iprd[gi*IPR_W +: IPR_W] == '0));
        end
    endgenerate

    assign o_bp_iprd[SRC_NUM*IPR_W-1:0] = i_wb_iprd;
    assign o_bp_data[SRC_NUM*XLEN-1:0]  = i_wb_data;

    // Each registered stage copies the one before it; squash deliberately does not touch them.
    generate
        for (gi = 1; gi < STG; gi++) begin : g_stage
            logic [SRC_NUM-1:0]       vld_reg;
            logic [SRC_NUM*IPR_W-1:0] iprd_reg;
            logic [SRC_NUM*XLEN-1:0]  data_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_reg  <= '0;
                    iprd_reg <= '0;
                    data_reg <= '0;
                end else begin
                    vld_reg  <= o_bp_vec[(gi-1)*SRC_NUM +: SRC_NUM];
                    iprd_reg <= o_bp_iprd[(gi-1)*SRC_NUM*IPR_W +: SRC_NUM*IPR_W];
                    data_reg <= o_bp_data[(gi-1)*SRC_NUM*XLEN +: SRC_NUM*XLEN];
                end
            end

            assign o_bp_vec[gi*SRC_NUM +: SRC_NUM]                = vld_reg;
            assign o_bp_iprd[gi*SRC_NUM*IPR_W +: SRC_NUM*IPR_W]  = iprd_reg;
            assign o_bp_data[gi*SRC_NUM*XLEN +: SRC_NUM*XLEN]    = data_reg;
        end
    endgenerate

`ifdef WBNET_LOOKUP_EN
    // Scan from oldest slot to newest so the lowest stage / lowest source wins last.
    generate
        for (gi = 0; gi < RD_NUM; gi++) begin : g_lk
            logic            hit_next;
            logic [XLEN-1:0] data_next;
            logic [IPR_W-1:0] idx;

            assign idx = i_lk_iprd[gi*IPR_W +: IPR_W];

            always_comb begin
                hit_next  = 1'b0;
                data_next = '0;
                for (int k = STG*SRC_NUM-1; k >= 0; k--) begin
                    if (o_bp_vec[k] && (o_bp_iprd[k*IPR_W +: IPR_W] == idx)) begin
                        hit_next  = 1'b1;
                        data_next = o_bp_data[k*XLEN +: XLEN];
                    end
                end
                if ((HAS_ZERO != 0) && (idx == '0)) begin
                    hit_next  = 1'b1;
                    data_next = '0;
                end
            end

            assign o_lk_hit[gi]              = hit_next;
            assign o_lk_data[gi*XLEN +: XLEN] = data_next;
        end
    endgenerate
`endif

    // ---------------- exception holder ----------------
    logic              cand_vld;
    logic [ROB_W-1:0]  cand_rob;
    logic [INFO_W-1:0] cand_info;
    logic [ROB_W-1:0]  src_rob;

    // Strictly-older replacement keeps ties with the lower source index.
    always_comb begin
        cand_vld  = 1'b0;
        cand_rob  = '0;
        cand_info = '0;
        src_rob   = '0;
        for (int i = 0; i < EXC_NUM; i++) begin
            src_rob = i_exc_robIdx[i*ROB_W +: ROB_W];
            if (i_exc_vld[i] &&
                !(i_squash_vld && !is_older(src_rob, i_squash_robIdx)) &&
                (!cand_vld || is_older(src_rob, cand_rob))) begin
                cand_vld  = 1'b1;
                cand_rob  = src_rob;
                cand_info = i_exc_info[i*INFO_W +: INFO_W];
            end
        end
    end

    logic              exc_vld_reg;
    logic [ROB_W-1:0]  exc_rob_reg;
    logic [INFO_W-1:0] exc_info_reg;
    logic              hold_free;

    assign hold_free = (exc_vld_reg && i_exc_ready) ||
                       (i_squash_vld && exc_vld_reg && !is_older(exc_rob_reg, i_squash_robIdx));

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_vld_reg  <= 1'b0;
            exc_rob_reg  <= '0;
            exc_info_reg <= '0;
        end else if (hold_free) begin
            // cand_* are zero when no candidate exists, so this also clears the holder.
            exc_vld_reg  <= cand_vld;
            exc_rob_reg  <= cand_rob;
            exc_info_reg <= cand_info;
        end else if (cand_vld && (!exc_vld_reg || is_older(cand_rob, exc_rob_reg))) begin
            exc_vld_reg  <= 1'b1;
            exc_rob_reg  <= cand_rob;
            exc_info_reg <= cand_info;
        end
    end

    assign o_exc_vld    = exc_vld_reg;
    assign o_exc_robIdx = exc_rob_reg;
    assign o_exc_info   = exc_info_reg;

endmodule

// File: tb/tb_wb_bypass_net.sv
// Directed bench for wb_bypass_net: a table of per-cycle vectors plus hand sequences
// for the bypass data path, lookup (when WBNET_LOOKUP_EN is defined) and mid-run reset.
module tb_wb_bypass_net;
    localparam int SRC = 10, STG = 3, EXC = 2, IW = 7, XL = 64, RW = 7, INW = 64, RD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic                   i_squash_vld;
    logic [RW-1:0]          i_squash_robIdx;
    logic [SRC-1:0]         i_wb_vld;
    logic [SRC*IW-1:0]      i_wb_iprd;
    logic [SRC*XL-1:0]      i_wb_data;
    logic [SRC*STG-1:0]     o_bp_vec;
    logic [SRC*STG*IW-1:0]  o_bp_iprd;
    logic [SRC*STG*XL-1:0]  o_bp_data;
    logic [EXC-1:0]         i_exc_vld;
    logic [EXC*RW-1:0]      i_exc_robIdx;
    logic [EXC*INW-1:0]     i_exc_info;
    logic                   o_exc_vld;
    logic                   i_exc_ready;
    logic [RW-1:0]          o_exc_robIdx;
    logic [INW-1:0]         o_exc_info;
`ifdef WBNET_LOOKUP_EN
    logic [RD*IW-1:0]       i_lk_iprd;
    logic [RD-1:0]          o_lk_hit;
    logic [RD*XL-1:0]       o_lk_data;
`endif

    wb_bypass_net dut (
        .clk(clk), .rst(rst),
        .i_squash_vld(i_squash_vld), .i_squash_robIdx(i_squash_robIdx),
        .i_wb_vld(i_wb_vld), .i_wb_iprd(i_wb_iprd), .i_wb_data(i_wb_data),
        .o_bp_vec(o_bp_vec), .o_bp_iprd(o_bp_iprd), .o_bp_data(o_bp_data),
`ifdef WBNET_LOOKUP_EN
        .i_lk_iprd(i_lk_iprd), .o_lk_hit(o_lk_hit), .o_lk_data(o_lk_data),
`endif
        .i_exc_vld(i_exc_vld), .i_exc_robIdx(i_exc_robIdx), .i_exc_info(i_exc_info),
        .o_exc_vld(o_exc_vld), .i_exc_ready(i_exc_ready),
        .o_exc_robIdx(o_exc_robIdx), .o_exc_info(o_exc_info)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One row = inputs held for one cycle; expectations are sampled before that cycle's edge.
    typedef struct {
        logic        wb_on;
        int          wb_src;
        logic [6:0]  wb_iprd;
        logic [63:0] wb_data;
        logic [1:0]  exc_vld;
        logic [6:0]  rob0;
        logic [6:0]  rob1;
        logic        ready;
        logic        sq;
        logic [6:0]  sq_idx;
        logic [29:0] exp_vec;
        logic        exp_vld;
        logic [6:0]  exp_rob;
        logic [63:0] exp_info;
    } vec_t;

    function automatic vec_t row(input logic on, input int src, input logic [6:0] iprd,
                                 input logic [63:0] data, input logic [1:0] ev,
                                 input logic [6:0] r0, input logic [6:0] r1, input logic rdy,
                                 input logic sq, input logic [6:0] sqi, input logic [29:0] xvec,
                                 input logic xvld, input logic [6:0] xrob, input logic [63:0] xinfo);
        vec_t r;
        r.wb_on = on; r.wb_src = src; r.wb_iprd = iprd; r.wb_data = data;
        r.exc_vld = ev; r.rob0 = r0; r.rob1 = r1; r.ready = rdy; r.sq = sq; r.sq_idx = sqi;
        r.exp_vec = xvec; r.exp_vld = xvld; r.exp_rob = xrob; r.exp_info = xinfo;
        return r;
    endfunction

    task automatic idle_inputs();
        i_wb_vld = '0; i_wb_iprd = '0; i_wb_data = '0;
        i_exc_vld = '0; i_exc_robIdx = '0; i_exc_info = '0;
        i_exc_ready = 1'b0; i_squash_vld = 1'b0; i_squash_robIdx = '0;
`ifdef WBNET_LOOKUP_EN
        i_lk_iprd = '0;
`endif
    endtask

    task automatic wb(input int src, input logic [6:0] iprd, input logic [63:0] data);
        i_wb_vld[src] = 1'b1;
        i_wb_iprd[src*IW +: IW] = iprd;
        i_wb_data[src*XL +: XL] = data;
    endtask

    // Source 0 payload is 0xA000|rob, source 1 payload is 0xB000|rob.
    task automatic drive_row(input vec_t r);
        idle_inputs();
        if (r.wb_on) wb(r.wb_src, r.wb_iprd, r.wb_data);
        i_exc_vld = r.exc_vld;
        i_exc_robIdx = {r.rob1, r.rob0};
        i_exc_info = {64'hB000 | 64'(r.rob1), 64'hA000 | 64'(r.rob0)};
        i_exc_ready = r.ready;
        i_squash_vld = r.sq;
        i_squash_robIdx = r.sq_idx;
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1;
        idle_inputs();

        tbl.push_back(row(0,0,0,0,      2'b00,0,0,0,0,0, 30'h0,      0,0,0));
        tbl.push_back(row(1,3,5,64'hAB, 2'b00,0,0,0,0,0, 30'h8,      0,0,0));
        tbl.push_back(row(0,0,0,0,      2'b00,0,0,0,0,0, 30'h2000,   0,0,0));
        tbl.push_back(row(0,0,0,0,      2'b00,0,0,0,0,0, 30'h800000, 0,0,0));
        tbl.push_back(row(0,0,0,0,      2'b00,0,0,0,0,0, 30'h0,      0,0,0));
        tbl.push_back(row(1,0,0,64'h55, 2'b00,0,0,0,0,0, 30'h0,      0,0,0));
        tbl.push_back(row(0,0,0,0,      2'b00,0,0,0,0,0, 30'h0,      0,0,0));
        tbl.push_back(row(0,0,0,0, 2'b11,7'h10,7'h0C,0,0,0,     30'h0, 0,7'h00,64'h0));
        tbl.push_back(row(0,0,0,0, 2'b01,7'h05,7'h00,0,0,0,     30'h0, 1,7'h0C,64'hB00C));
        tbl.push_back(row(0,0,0,0, 2'b01,7'h20,7'h00,0,0,0,     30'h0, 1,7'h05,64'hA005));
        tbl.push_back(row(0,0,0,0, 2'b00,7'h00,7'h00,0,0,0,     30'h0, 1,7'h05,64'hA005));
        tbl.push_back(row(0,0,0,0, 2'b00,7'h00,7'h00,1,0,0,     30'h0, 1,7'h05,64'hA005));
        tbl.push_back(row(0,0,0,0, 2'b00,7'h00,7'h00,0,0,0,     30'h0, 0,7'h00,64'h0));
        tbl.push_back(row(0,0,0,0, 2'b10,7'h00,7'h42,0,0,0,     30'h0, 0,7'h00,64'h0));
        tbl.push_back(row(0,0,0,0, 2'b01,7'h3E,7'h00,0,0,0,     30'h0, 1,7'h42,64'hB042));
        tbl.push_back(row(0,0,0,0, 2'b00,7'h00,7'h00,0,0,0,     30'h0, 1,7'h3E,64'hA03E));
        tbl.push_back(row(0,0,0,0, 2'b01,7'h12,7'h00,1,0,0,     30'h0, 1,7'h3E,64'hA03E));
        tbl.push_back(row(0,0,0,0, 2'b00,7'h00,7'h00,0,1,7'h10, 30'h0, 1,7'h12,64'hA012));
        tbl.push_back(row(0,0,0,0, 2'b00,7'h00,7'h00,0,0,0,     30'h0, 0,7'h00,64'h0));
        tbl.push_back(row(0,0,0,0, 2'b01,7'h12,7'h00,0,0,0,     30'h0, 0,7'h00,64'h0));
        tbl.push_back(row(0,0,0,0, 2'b10,7'h00,7'h0F,0,1,7'h10, 30'h0, 1,7'h12,64'hA012));
        tbl.push_back(row(0,0,0,0, 2'b00,7'h00,7'h00,0,0,0,     30'h0, 1,7'h0F,64'hB00F));
        tbl.push_back(row(0,0,0,0, 2'b11,7'h11,7'h13,1,1,7'h10, 30'h0, 1,7'h0F,64'hB00F));
        tbl.push_back(row(0,0,0,0, 2'b00,7'h00,7'h00,0,0,0,     30'h0, 0,7'h00,64'h0));
        tbl.push_back(row(0,0,0,0, 2'b11,7'h30,7'h30,0,0,0,     30'h0, 0,7'h00,64'h0));
        tbl.push_back(row(0,0,0,0, 2'b00,7'h00,7'h00,0,0,0,     30'h0, 1,7'h30,64'hA030));
        tbl.push_back(row(0,0,0,0, 2'b00,7'h00,7'h00,0,1,7'h40, 30'h0, 1,7'h30,64'hA030));
        tbl.push_back(row(0,0,0,0, 2'b00,7'h00,7'h00,0,0,0,     30'h0, 1,7'h30,64'hA030));
        tbl.push_back(row(0,0,0,0, 2'b00,7'h00,7'h00,0,1,7'h30, 30'h0, 1,7'h30,64'hA030));
        tbl.push_back(row(0,0,0,0, 2'b00,7'h00,7'h00,0,0,0,     30'h0, 0,7'h00,64'h0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive_row(tbl[i]);
            #1;
            chk($sformatf("row%0d_bp_vec", i), 64'(o_bp_vec), 64'(tbl[i].exp_vec));
            chk($sformatf("row%0d_exc_vld", i), 64'(o_exc_vld), 64'(tbl[i].exp_vld));
            chk($sformatf("row%0d_exc_rob", i), 64'(o_exc_robIdx), 64'(tbl[i].exp_rob));
            chk($sformatf("row%0d_exc_info", i), o_exc_info, tbl[i].exp_info);
            $display("row %0d vec=%h exc_vld=%0d rob=%h", i, o_bp_vec, o_exc_vld, o_exc_robIdx);
            @(negedge clk);
        end

        // Bypass index/data travel through the stages at flat slot 7, 17, 27.
        idle_inputs();
        wb(7, 7'h33, 64'h1234_5678_9ABC_DEF0);
        #1;
        chk("dp_s0_iprd", 64'(o_bp_iprd[7*IW +: IW]), 64'h33);
        chk("dp_s0_data", o_bp_data[7*XL +: XL], 64'h1234_5678_9ABC_DEF0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("dp_s1_vec", 64'(o_bp_vec), 64'h20000);
        chk("dp_s1_iprd", 64'(o_bp_iprd[17*IW +: IW]), 64'h33);
        chk("dp_s1_data", o_bp_data[17*XL +: XL], 64'h1234_5678_9ABC_DEF0);
        @(negedge clk);
        #1;
        chk("dp_s2_vec", 64'(o_bp_vec), 64'h8000000);
        chk("dp_s2_iprd", 64'(o_bp_iprd[27*IW +: IW]), 64'h33);
        chk("dp_s2_data", o_bp_data[27*XL +: XL], 64'h1234_5678_9ABC_DEF0);
        @(negedge clk);
        #1;
        chk("dp_gone_vec", 64'(o_bp_vec), 64'h0);
        $display("datapath sequence done");

`ifdef WBNET_LOOKUP_EN
        @(negedge clk);
        idle_inputs();
        wb(2, 7'd9, 64'h111);
        @(negedge clk);
        idle_inputs();
        wb(4, 7'd9, 64'h222);
        i_lk_iprd = {7'd0, 7'h3A, 7'd0, 7'd9};
        #1;
        chk("lk_newest_hit", 64'(o_lk_hit[0]), 64'h1);
        chk("lk_newest_data", o_lk_data[0 +: XL], 64'h222);
        chk("lk_zero_hit", 64'(o_lk_hit[1]), 64'h1);
        chk("lk_zero_data", o_lk_data[XL +: XL], 64'h0);
        chk("lk_miss_hit", 64'(o_lk_hit[2]), 64'h0);
        @(negedge clk);
        idle_inputs();
        wb(1, 7'd11, 64'h333);
        wb(6, 7'd11, 64'h444);
        i_lk_iprd = {7'd11, 7'd0, 7'd0, 7'd9};
        #1;
        chk("lk_stage1_data", o_lk_data[0 +: XL], 64'h222);
        chk("lk_src_prio_data", o_lk_data[3*XL +: XL], 64'h333);
        $display("lookup sequence done");
`endif

        // Reset while the holder and bypass stages are live.
        @(negedge clk);
        idle_inputs();
        i_exc_vld = 2'b01;
        i_exc_robIdx = {7'h00, 7'h22};
        i_exc_info = {64'h0, 64'hA022};
        @(negedge clk);
        idle_inputs();
        #1;
        chk("pre_rst_exc_vld", 64'(o_exc_vld), 64'h1);
        chk("pre_rst_exc_rob", 64'(o_exc_robIdx), 64'h22);
        rst = 1'b1;
        wb(1, 7'd3, 64'h77);
        @(negedge clk);
        #1;
        chk("rst_exc_vld", 64'(o_exc_vld), 64'h0);
        chk("rst_exc_rob", 64'(o_exc_robIdx), 64'h0);
        chk("rst_exc_info", o_exc_info, 64'h0);
        chk("rst_bp_regs", 64'(o_bp_vec[29:10]), 64'h0);
        chk("rst_bp_s0", 64'(o_bp_vec[9:0]), 64'h2);
        $display("reset sequence done");
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
